midi_msg_parser: RTL and testbench
==================================

// Module: midi_msg_parser
// PURPOSE
//  Turns the UART receiver's MIDI byte stream into one-cycle event strobes with
//  note, velocity and channel fields, and feeds those strobes into the synth
//  voice controller's event FIFO.
//  Handles running status, note-on with velocity 0 as note-off, sysex skipping
//  and real-time byte passthrough. Raises a debug read-back strobe on one
//  chosen control-change number.
// PARAMETERS
//  DEBUG_CC   7'h77  controller number that raises read_back; the CC value goes on velocity
//  OMNI       1      1 = accept all channels; 0 = accept only LISTEN_CH
//  LISTEN_CH  4'h0   channel accepted when OMNI=0
// PORTS
//  clk32             in   1  system clock, 32 MHz
//  rst_n             in   1  asynchronous active-low reset
//  rx_data           in   8  received MIDI byte
//  rx_valid          in   1  one-cycle strobe: rx_data is valid
//  note_pressed      out  1  one-cycle strobe: note-on with velocity != 0
//  note_released     out  1  one-cycle strobe: note-off, or note-on with velocity 0
//  note_keypress     out  1  one-cycle strobe: polyphonic aftertouch (An)
//  note_channelpress out  1  one-cycle strobe: channel pressure (Dn)
//  read_back         out  1  one-cycle strobe: CC message with number DEBUG_CC
//  note_interface    out  7  note number (for Dn: the pressure value)
//  velocity          out  7  velocity, pressure or CC value
//  channel           out  4  MIDI channel, low nibble of the status byte
//  drop_cnt          out  8  saturating count of discarded bytes and messages
// BEHAVIOUR
//  Reset values: all strobes 0; note_interface, velocity, channel = 0; drop_cnt = 0;
//  running status cleared; FSM in IDLE. Reset is asynchronous and can abort a
//  message partway through; no strobe may follow the abort.
//  Byte classes:
//  - status: bit7=1
//  - real-time: F8..FF
//  - channel status: 80..EF
//  - system common: F0..F7
//  Real-time bytes are ignored in every state. They change no state, field or counter.
//  Data bytes per channel status:
//  - 8n, 9n, An, Bn, En: 2 data bytes
//  - Cn, Dn: 1 data byte
//  FSM states: IDLE, WAIT_D1, WAIT_D2, SYSEX.
//  - IDLE:
//    - channel status -> latch status, go to WAIT_D1
//    - F0 -> SYSEX
//    - data byte -> drop, drop_cnt+1
//    - other system common -> stay in IDLE
//  - WAIT_D1:
//    - data byte -> latch d1; go to WAIT_D2 for 2-byte messages
//    - for 1-byte messages: complete the message, back to WAIT_D1 (running status)
//  - WAIT_D2: data byte -> complete the message, back to WAIT_D1 (running status)
//  - Any channel status in WAIT_D1/WAIT_D2: abort the partial message
//    (drop_cnt+1), latch the new status, go to WAIT_D1.
//  - Any system common in WAIT_D1/WAIT_D2: clear running status
//    (drop_cnt+1 if partial); F0 -> SYSEX, else IDLE.
//  - SYSEX:
//    - data bytes -> discard, not counted
//    - F7 -> IDLE
//    - channel status -> latch it, go to WAIT_D1 (unterminated sysex is accepted)
//    - other system common -> IDLE
//  On message completion:
//  - Update channel, note_interface and velocity.
//  - Assert exactly one strobe on the cycle after the rx_valid of the final byte
//    (latency 1). The fields hold until the next completed message.
//  - Strobe per message type:
//    - 9n with vel != 0 -> note_pressed
//    - 9n with vel == 0 -> note_released, velocity = 0
//    - 8n -> note_released
//    - An -> note_keypress
//    - Dn -> note_channelpress; note_interface = pressure, velocity = pressure
//    - Bn with d1 == DEBUG_CC -> read_back, velocity = d2
//    - other Bn, Cn, En -> complete the message silently: no strobe, no field update
//  - If OMNI=0 and channel != LISTEN_CH: no strobe, no field update, drop_cnt+1.
//  drop_cnt saturates at 8'hFF and holds; it clears only on reset.
//  Back-to-back rx_valid on consecutive cycles is supported. At most one
//  strobe is asserted per cycle.
// TESTING
//  T1: 90 3C 64 -> note_pressed=1 for 1 cycle, note_interface=3C, velocity=64, channel=0; latency 1.
//  T2: 91 40 50 40 00 (running status) -> note_pressed (40/50/ch1), then note_released (40/00/ch1).
//  T3: 92 F8 3C F8 7F -> note_pressed 3C/7F/ch2; the F8 bytes change no state and drop_cnt stays 0.
//  T4: F0 11 22 33 F7 3C 90 3C 01 -> no strobe for the sysex; stray 3C gives drop_cnt=1; then note_pressed 3C/01.
//  T5: 90 3C B0 77 02 -> drop_cnt=1 (aborted note-on); read_back=1 with velocity=02, channel=0.
//  T6: OMNI=0, LISTEN_CH=3; 95 3C 64 -> no strobe, drop_cnt=1. Then 93 3C 64 -> note_pressed.
//      rst_n low after 93 3C -> all outputs 0; the following 64 is dropped.

Source files
------------

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: turns channel messages into one-cycle event strobes with
// note/velocity/channel fields, honouring running status, sysex skipping and real-time bytes.
module midi_msg_parser #(
  parameter logic [6:0] DEBUG_CC  = 7'h77,
  parameter bit         OMNI      = 1'b1,
  parameter logic [3:0] LISTEN_CH = 4'h0
) (
  input  logic       clk32,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       note_pressed,
  output logic       note_released,
  output logic       note_keypress,
  output logic       note_channelpress,
  output logic       read_back,
  output logic [6:0] note_interface,
  output logic [6:0] velocity,
  output logic [3:0] channel,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  state_t     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic       partial_q, partial_d;
  logic       pressed_q, pressed_d;
  logic       released_q, released_d;
  logic       keypress_q, keypress_d;
  logic       chpress_q, chpress_d;
  logic       readback_q, readback_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic [3:0] ch_q, ch_d;
  logic [7:0] drop_q, drop_d;

  logic       is_status, is_rt, is_chan, is_sys;
  logic       two_byte, chan_ok, msg_done, drop_inc;
  logic [6:0] data1, data2;

  assign is_status = rx_data[7];
  assign is_rt     = (rx_data[7:3] == 5'b11111);
  assign is_chan   = rx_data[7] && (rx_data[7:4] != 4'hF);
  assign is_sys    = (rx_data[7:4] == 4'hF) && !rx_data[3];
  assign two_byte  = (status_q[7:4] != 4'hC) && (status_q[7:4] != 4'hD);
  assign chan_ok   = OMNI || (status_q[3:0] == LISTEN_CH);
  // For 1-byte messages the only data byte arrives in WAIT_D1, so it doubles as d1.
  assign data1     = (state_q == WAIT_D2) ? d1_q : rx_data[6:0];
  assign data2     = rx_data[6:0];

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    d1_d       = d1_q;
    partial_d  = partial_q;
    msg_done   = 1'b0;
    drop_inc   = 1'b0;
    if (rx_valid && !is_rt) begin
      case (state_q)
        IDLE: begin
          if (is_chan) begin
            status_d  = rx_data;
            partial_d = 1'b1;
            state_d   = WAIT_D1;
          end else if (rx_data == 8'hF0) begin
            state_d = SYSEX;
          end else if (!is_status) begin
            drop_inc = 1'b1;
          end
        end
        WAIT_D1, WAIT_D2: begin
          if (is_chan) begin
            drop_inc  = partial_q;
            status_d  = rx_data;
            partial_d = 1'b1;
            state_d   = WAIT_D1;
          end else if (is_sys) begin
            drop_inc  = partial_q;
            status_d  = '0;
            partial_d = 1'b0;
            state_d   = (rx_data == 8'hF0) ? SYSEX : IDLE;
          end else if ((state_q == WAIT_D1) && two_byte) begin
            d1_d      = rx_data[6:0];
            partial_d = 1'b1;
            state_d   = WAIT_D2;
          end else begin
            msg_done  = 1'b1;
            partial_d = 1'b0;
            state_d   = WAIT_D1;
          end
        end
        SYSEX: begin
          if (is_chan) begin
            status_d  = rx_data;
            partial_d = 1'b1;
            state_d   = WAIT_D1;
          end else if (is_sys) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pressed_d  = 1'b0;
    released_d = 1'b0;
    keypress_d = 1'b0;
    chpress_d  = 1'b0;
    readback_d = 1'b0;
    note_d     = note_q;
    vel_d      = vel_q;
    ch_d       = ch_q;
    if (msg_done) begin
      if (!chan_ok) begin
        // counted as a drop in the sequential block via drop_cnt_inc
      end else begin
        case (status_q[7:4])
          4'h8: begin
            released_d = 1'b1;
            note_d = data1; vel_d = data2; ch_d = status_q[3:0];
          end
          4'h9: begin
            pressed_d  = (data2 != 7'd0);
            released_d = (data2 == 7'd0);
            note_d = data1; vel_d = data2; ch_d = status_q[3:0];
          end
          4'hA: begin
            keypress_d = 1'b1;
            note_d = data1; vel_d = data2; ch_d = status_q[3:0];
          end
          4'hB: begin
            if (data1 == DEBUG_CC) begin
              readback_d = 1'b1;
              note_d = data1; vel_d = data2; ch_d = status_q[3:0];
            end
          end
          4'hD: begin
            chpress_d = 1'b1;
            note_d = data2; vel_d = data2; ch_d = status_q[3:0];
          end
          default: ;
        endcase
      end
    end
  end

  logic drop_cnt_inc;
  assign drop_cnt_inc = drop_inc || (msg_done && !chan_ok);
  assign drop_d = (drop_cnt_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      status_q   <= '0;
      d1_q       <= '0;
      partial_q  <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      keypress_q <= 1'b0;
      chpress_q  <= 1'b0;
      readback_q <= 1'b0;
      note_q     <= '0;
      vel_q      <= '0;
      ch_q       <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      d1_q       <= d1_d;
      partial_q  <= partial_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      keypress_q <= keypress_d;
      chpress_q  <= chpress_d;
      readback_q <= readback_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      ch_q       <= ch_d;
      drop_q     <= drop_d;
    end
  end

  assign note_pressed      = pressed_q;
  assign note_released     = released_q;
  assign note_keypress     = keypress_q;
  assign note_channelpress = chpress_q;
  assign read_back         = readback_q;
  assign note_interface    = note_q;
  assign velocity          = vel_q;
  assign channel           = ch_q;
  assign drop_cnt          = drop_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Scoreboard bench for midi_msg_parser: an OMNI instance (A) and a channel-3-only instance (B).
module tb_midi_msg_parser;

  logic clk32 = 1'b0;
  always #15 clk32 = ~clk32;

  logic       rst_n;
  logic [7:0] rxd_a, rxd_b;
  logic       rxv_a, rxv_b;
  logic       pr_a, rl_a, kp_a, cp_a, rb_a, pr_b, rl_b, kp_b, cp_b, rb_b;
  logic [6:0] ni_a, ve_a, ni_b, ve_b;
  logic [3:0] ch_a, ch_b;
  logic [7:0] dc_a, dc_b;

  midi_msg_parser #(.DEBUG_CC(7'h77), .OMNI(1'b1), .LISTEN_CH(4'h0)) dut_a (
    .clk32(clk32), .rst_n(rst_n), .rx_data(rxd_a), .rx_valid(rxv_a),
    .note_pressed(pr_a), .note_released(rl_a), .note_keypress(kp_a),
    .note_channelpress(cp_a), .read_back(rb_a), .note_interface(ni_a),
    .velocity(ve_a), .channel(ch_a), .drop_cnt(dc_a));

  midi_msg_parser #(.DEBUG_CC(7'h77), .OMNI(1'b0), .LISTEN_CH(4'h3)) dut_b (
    .clk32(clk32), .rst_n(rst_n), .rx_data(rxd_b), .rx_valid(rxv_b),
    .note_pressed(pr_b), .note_released(rl_b), .note_keypress(kp_b),
    .note_channelpress(cp_b), .read_back(rb_b), .note_interface(ni_b),
    .velocity(ve_b), .channel(ch_b), .drop_cnt(dc_b));

  // strobe vector layout: {read_back, channelpress, keypress, released, pressed}
  localparam logic [4:0] K_PR = 5'b00001, K_RL = 5'b00010, K_KP = 5'b00100,
                         K_CP = 5'b01000, K_RB = 5'b10000;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  kind;
    logic [6:0]  note;
    logic [6:0]  vel;
    logic [3:0]  ch;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(posedge clk32) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic mon(input bit sel, input logic [4:0] stb, input logic [6:0] ni,
                     input logic [6:0] ve, input logic [3:0] ch);
    ev_t   e;
    string nm;
    int    qs;
    nm = sel ? "B" : "A";
    qs = sel ? q_b.size() : q_a.size();
    if (stb != 5'd0) begin
      if (qs == 0) begin
        n_checks++;
        $display("FAIL %s unexpected strobe: got %b at cycle %0d expected none", nm, stb, cyc);
      end else begin
        if (sel) e = q_b.pop_front(); else e = q_a.pop_front();
        chk({nm, " strobe"}, 32'(stb), 32'(e.kind));
        chk({nm, " latency cycle"}, cyc, e.cyc);
        chk({nm, " note"}, 32'(ni), 32'(e.note));
        chk({nm, " velocity"}, 32'(ve), 32'(e.vel));
        chk({nm, " channel"}, 32'(ch), 32'(e.ch));
      end
    end else if (qs != 0) begin
      if (sel) e = q_b[0]; else e = q_a[0];
      if (e.cyc <= cyc) begin
        n_checks++;
        $display("FAIL %s missing strobe: got none at cycle %0d expected %b", nm, cyc, e.kind);
        if (sel) void'(q_b.pop_front()); else void'(q_a.pop_front());
      end
    end
  endtask

  always @(negedge clk32) begin
    mon(1'b0, {rb_a, cp_a, kp_a, rl_a, pr_a}, ni_a, ve_a, ch_a);
    mon(1'b1, {rb_b, cp_b, kp_b, rl_b, pr_b}, ni_b, ve_b, ch_b);
  end

  task automatic drive(input bit sel, input logic [7:0] b);
    if (sel) begin rxd_b = b; rxv_b = 1'b1; end
    else     begin rxd_a = b; rxv_a = 1'b1; end
    @(posedge clk32); #1;
    rxv_a = 1'b0;
    rxv_b = 1'b0;
  endtask

  // Push the event expected from the byte driven next (one cycle of latency).
  task automatic expect_ev(input bit sel, input logic [4:0] kind, input logic [6:0] note,
                           input logic [6:0] vel, input logic [3:0] ch);
    ev_t e;
    e.cyc = cyc + 1; e.kind = kind; e.note = note; e.vel = vel; e.ch = ch;
    if (sel) q_b.push_back(e); else q_a.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk32); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rxv_a = 1'b0; rxv_b = 1'b0; rxd_a = '0; rxd_b = '0;
    idle(3);
    chk("A reset outputs", {rb_a, cp_a, kp_a, rl_a, pr_a, ni_a, ve_a, ch_a, dc_a}, 32'd0);
    chk("B reset outputs", {rb_b, cp_b, kp_b, rl_b, pr_b, ni_b, ve_b, ch_b, dc_b}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // T1
    drive(0, 8'h90); drive(0, 8'h3C);
    expect_ev(0, K_PR, 7'h3C, 7'h64, 4'h0); drive(0, 8'h64);
    idle(2);
    chk("T1 fields hold", {ni_a, ve_a, ch_a}, {7'h3C, 7'h64, 4'h0});
    chk("T1 drop_cnt", dc_a, 32'd0);

    // T2 running status
    drive(0, 8'h91); drive(0, 8'h40);
    expect_ev(0, K_PR, 7'h40, 7'h50, 4'h1); drive(0, 8'h50);
    drive(0, 8'h40);
    expect_ev(0, K_RL, 7'h40, 7'h00, 4'h1); drive(0, 8'h00);
    idle(2);
    chk("T2 fields hold", {ni_a, ve_a, ch_a}, {7'h40, 7'h00, 4'h1});

    // T3 real-time interleaved
    drive(0, 8'h92); drive(0, 8'hF8); drive(0, 8'h3C); drive(0, 8'hF8);
    expect_ev(0, K_PR, 7'h3C, 7'h7F, 4'h2); drive(0, 8'h7F);
    idle(2);
    chk("T3 drop_cnt", dc_a, 32'd0);

    // T4 sysex then stray data
    do_reset();
    drive(0, 8'hF0); drive(0, 8'h11); drive(0, 8'h22); drive(0, 8'h33); drive(0, 8'hF7);
    drive(0, 8'h3C); drive(0, 8'h90); drive(0, 8'h3C);
    expect_ev(0, K_PR, 7'h3C, 7'h01, 4'h0); drive(0, 8'h01);
    idle(2);
    chk("T4 drop_cnt", dc_a, 32'd1);

    // T5 abort then debug CC
    do_reset();
    drive(0, 8'h90); drive(0, 8'h3C); drive(0, 8'hB0); drive(0, 8'h77);
    expect_ev(0, K_RB, 7'h77, 7'h02, 4'h0); drive(0, 8'h02);
    idle(2);
    chk("T5 drop_cnt", dc_a, 32'd1);

    // Other message types, silent completions, sysex closed by channel status
    do_reset();
    drive(0, 8'hA5); drive(0, 8'h3C);
    expect_ev(0, K_KP, 7'h3C, 7'h40, 4'h5); drive(0, 8'h40);
    drive(0, 8'hD7);
    expect_ev(0, K_CP, 7'h55, 7'h55, 4'h7); drive(0, 8'h55);
    expect_ev(0, K_CP, 7'h66, 7'h66, 4'h7); drive(0, 8'h66);
    drive(0, 8'hC0); drive(0, 8'h05);
    drive(0, 8'hB0); drive(0, 8'h10); drive(0, 8'h20);
    drive(0, 8'hE0); drive(0, 8'h00); drive(0, 8'h40);
    idle(2);
    chk("silent msgs keep fields", {ni_a, ve_a, ch_a}, {7'h66, 7'h66, 4'h7});
    drive(0, 8'h83); drive(0, 8'h3C);
    expect_ev(0, K_RL, 7'h3C, 7'h40, 4'h3); drive(0, 8'h40);
    drive(0, 8'hF0); drive(0, 8'h01); drive(0, 8'h02); drive(0, 8'h94); drive(0, 8'h3C);
    expect_ev(0, K_PR, 7'h3C, 7'h10, 4'h4); drive(0, 8'h10);
    idle(2);
    chk("types drop_cnt", dc_a, 32'd0);

    // System common clears running status; partial message counted
    do_reset();
    drive(0, 8'h90); drive(0, 8'h3C);
    expect_ev(0, K_PR, 7'h3C, 7'h64, 4'h0); drive(0, 8'h64);
    drive(0, 8'hF6); drive(0, 8'h3C); drive(0, 8'h40);
    idle(2);
    chk("running status cleared", dc_a, 32'd2);
    drive(0, 8'h90); drive(0, 8'h3C); drive(0, 8'hF2);
    idle(2);
    chk("partial before sys common", dc_a, 32'd3);

    // Saturation
    do_reset();
    repeat (254) drive(0, 8'h01);
    idle(1);
    chk("drop_cnt 254", dc_a, 32'hFE);
    repeat (6) drive(0, 8'h7F);
    idle(1);
    chk("drop_cnt saturates", dc_a, 32'hFF);

    // T6 channel filter on B
    do_reset();
    drive(1, 8'h95); drive(1, 8'h3C); drive(1, 8'h64);
    idle(2);
    chk("T6 filtered drop_cnt", dc_b, 32'd1);
    chk("T6 filtered fields", {ni_b, ve_b, ch_b}, 32'd0);
    drive(1, 8'h93); drive(1, 8'h3C);
    expect_ev(1, K_PR, 7'h3C, 7'h64, 4'h3); drive(1, 8'h64);
    idle(2);
    drive(1, 8'h93); drive(1, 8'h3C);
    rst_n = 1'b0;
    #2;
    chk("T6 async reset outputs",
        {rb_b, cp_b, kp_b, rl_b, pr_b, ni_b, ve_b, ch_b, dc_b}, 32'd0);
    idle(1);
    rst_n = 1'b1;
    drive(1, 8'h64);
    idle(2);
    chk("T6 post-reset drop_cnt", dc_b, 32'd1);

    idle(3);
    while (q_a.size() != 0) begin
      n_checks++;
      $display("FAIL A leftover event: got none expected %b", q_a[0].kind);
      void'(q_a.pop_front());
    end
    while (q_b.size() != 0) begin
      n_checks++;
      $display("FAIL B leftover event: got none expected %b", q_b[0].kind);
      void'(q_b.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
